// File: rtl/uart_rx_byte.sv
// uart_rx_byte: serial-to-byte receiver for the Tiny CPU programming path.
// Deserialises 8N1 UART frames (8E1/8O1 when UART_RX_PARITY_EN is defined)
// into bytes.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (legal 4..65535)
//   PARITY_ODD    0 = even parity, 1 = odd; only used with UART_RX_PARITY_EN
//
// Ports:
//   CLK             system clock
//   RST             asynchronous, active-low reset
//   Rx_Serial_in    raw UART line, asynchronous to CLK, idle high
//   Rx_Byte_out     last good received byte, updated only on a good frame
//   Rx_Valid_out    one-cycle pulse, Rx_Byte_out is new
//   Frame_Err_out   one-cycle pulse, stop bit sampled low
//   Parity_Err_out  one-cycle pulse, parity mismatch (0 without the macro)
//   Busy_out        high whenever the receiver is not idle
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data).
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx_Serial_in,
  output logic [7:0] Rx_Byte_out,
  output logic       Rx_Valid_out,
  output logic       Frame_Err_out,
  output logic       Parity_Err_out,
  output logic       Busy_out
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      sh, sh_nxt;
  logic [7:0]      byte_nxt;
  logic            valid_nxt;
  logic            ferr_nxt;
  logic            bit_end;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic            par_bad, par_bad_nxt;
  logic            perr_nxt;
`endif

  // Two-flop synchroniser; resets to idle-high so reset never fakes a start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '1;
    else      sync_q <= {sync_q[0], Rx_Serial_in};
  end
  assign rx_s = sync_q[1];

  assign bit_end  = (cnt == CNT_BIT_END);
  assign Busy_out = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      sh            <= '0;
      Rx_Byte_out   <= '0;
      Rx_Valid_out  <= 1'b0;
      Frame_Err_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      sh            <= sh_nxt;
      Rx_Byte_out   <= byte_nxt;
      Rx_Valid_out  <= valid_nxt;
      Frame_Err_out <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bad        <= 1'b0;
      Parity_Err_out <= 1'b0;
    end else begin
      par_bad        <= par_bad_nxt;
      Parity_Err_out <= perr_nxt;
    end
  end
`else
  assign Parity_Err_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    byte_nxt  = Rx_Byte_out;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end

      // Recheck at mid-start-bit; a high line here was a glitch.
      START: begin
        if (cnt == CNT_HALF_END) begin
          if (!rx_s) begin
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          sh_nxt[idx] = rx_s;
          cnt_nxt     = '0;
          idx_nxt     = idx + 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_nxt     = '0;
          par_bad_nxt = ((^sh) ^ rx_s) != PAR_SENSE;
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif

      // Leaves at mid-stop-bit so a back-to-back start edge is not missed.
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              perr_nxt = 1'b1;
            end else begin
              byte_nxt  = sh;
              valid_nxt = 1'b1;
            end
`else
            byte_nxt  = sh;
            valid_nxt = 1'b1;
`endif
          end else begin
            ferr_nxt  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_nxt  = par_bad;
`endif
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      // Held-low line after a framing error must not look like a new start.
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_CYC = CPB;
`else
  localparam int PAR_CYC = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] byte_out;
  logic       valid, ferr, perr, busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Rx_Serial_in  (rx),
    .Rx_Byte_out   (byte_out),
    .Rx_Valid_out  (valid),
    .Frame_Err_out (ferr),
    .Parity_Err_out(perr),
    .Busy_out      (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] b;
  } exp_t;
  exp_t sb[$];

  logic [7:0] last_good = 8'h00;
  int         pulses = 0;
  int         last_valid_cyc = -1;
  logic       prev_any = 1'b0;
  logic       any;
  exp_t       got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic v, input logic f, input logic p, input logic [7:0] d);
    exp_t e;
    e.v = v;
    e.f = f;
    e.p = p;
    e.b = v ? d : last_good;
    if (v) last_good = d;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic frame_body(input logic [7:0] d, input logic flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip);
`else
    if (flip) rx = 1'b1;
`endif
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic flip, input int gap);
    frame_body(d, flip);
    drive_bit(stop);
    rx = 1'b1;
    repeat (gap * CPB) @(negedge CLK);
  endtask

  // Scoreboard consumer: every output pulse must match the next expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      prev_any = 1'b0;
    end else begin
      any = valid | ferr | perr;
      if (prev_any) check("pulse_width", {31'd0, any}, 0);
      if (any) begin
        pulses++;
        if (valid) last_valid_cyc = cyc;
        check("valid_with_err", {31'd0, valid & (ferr | perr)}, 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {29'd0, valid, ferr, perr}, 0);
        end else begin
          got = sb.pop_front();
          check("pulse_kind", {29'd0, valid, ferr, perr}, {29'd0, got.v, got.f, got.p});
          check("byte_out", {24'd0, byte_out}, {24'd0, got.b});
        end
      end
      prev_any = any;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       flip;
    int         gap;
    logic       exp_v;
    logic       exp_f;
    logic       exp_p;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int t0;
    int lat;
    int p0;
    logic busy_seen;

    // back-to-back 01, FF, 00 then assorted frames with gaps
    tbl[0] = '{8'h01, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'hE7, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h6B, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h9D, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};

    RST = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge CLK);
    check("rst_byte", {24'd0, byte_out}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_ferr", {31'd0, ferr}, 0);
    check("rst_perr", {31'd0, perr}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    RST = 1'b1;
    busy_seen = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      busy_seen = busy_seen | busy;
    end
    check("busy_after_release", {31'd0, busy_seen}, 0);

    // single frame A5 with latency measurement from the pin falling edge
    t0 = cyc;
    push_exp(1'b1, 1'b0, 1'b0, 8'hA5);
    send(8'hA5, 1'b1, 1'b0, 1);
    lat = last_valid_cyc - t0;
    if (lat >= 154 + PAR_CYC && lat <= 156 + PAR_CYC)
      check("a5_latency", 155 + PAR_CYC, 155 + PAR_CYC + 0 * lat);
    else
      check("a5_latency", lat, 155 + PAR_CYC);

    for (int i = 0; i < 7; i++) begin
      push_exp(tbl[i].exp_v, tbl[i].exp_f, tbl[i].exp_p, tbl[i].d);
      send(tbl[i].d, tbl[i].stop, tbl[i].flip, tbl[i].gap);
    end

    // framing error on 3C, then line held low 40 cycles past the stop bit
    push_exp(1'b0, 1'b1, 1'b0, 8'h3C);
    frame_body(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (CPB + 40) @(negedge CLK);
    check("busy_in_break", {31'd0, busy}, 1);
    p0 = pulses;
    rx = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    check("no_spurious_after_break", pulses, p0);
    check("idle_after_break", {31'd0, busy}, 0);
    push_exp(1'b1, 1'b0, 1'b0, 8'h55);
    send(8'h55, 1'b1, 1'b0, 1);

    // 5-cycle glitch on the idle line
    p0 = pulses;
    rx = 1'b0;
    repeat (5) @(negedge CLK);
    rx = 1'b1;
    for (int i = 0; i < 8 && busy; i++) @(negedge CLK);
    check("glitch_busy_fall", {31'd0, busy}, 0);
    repeat (2 * CPB) @(negedge CLK);
    check("glitch_no_pulse", pulses, p0);

`ifdef UART_RX_PARITY_EN
    push_exp(1'b1, 1'b0, 1'b0, 8'h07);
    send(8'h07, 1'b1, 1'b0, 1);
    push_exp(1'b0, 1'b0, 1'b1, 8'h07);
    send(8'h07, 1'b1, 1'b1, 1);
`endif

    // reset in the middle of the data bits of C3 (LSB first: 1,1,0,...)
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RST = 1'b0;
    rx  = 1'b1;
    @(negedge CLK);
    check("midrst_byte", {24'd0, byte_out}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_pulses", {29'd0, valid, ferr, perr}, 0);
    last_good = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    push_exp(1'b1, 1'b0, 1'b0, 8'h12);
    send(8'h12, 1'b1, 1'b0, 2);

    repeat (4 * CPB) @(negedge CLK);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial-to-byte receiver for the Tiny CPU programming path. It deserialises 8N1 UART frames from the host into 8-bit words. Each good byte is presented with a one-cycle valid strobe, which the controller uses to raise the instruction-load enable into the instruction register. It sits between the board RX pin and the instruction/controller logic.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 4..65535.
- PARITY_ODD, default 0: used only with `UART_RX_PARITY_EN`. 0 selects even parity, 1 selects odd.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- Rx_Serial_in  in  1  raw UART line, asynchronous to CLK, idle high
- Rx_Byte_out  out  8  last good received byte; updates only on a good frame
- Rx_Valid_out  out  1  one-cycle pulse, Rx_Byte_out is new
- Frame_Err_out  out  1  one-cycle pulse, stop bit sampled low
- Parity_Err_out  out  1  one-cycle pulse, parity mismatch; constant 0 when the macro is absent
- Busy_out  out  1  high in any state other than IDLE

## Operation
- Input path: two-flop synchroniser on Rx_Serial_in, reset to 1. Every decision in this spec uses the synchronised line `rx_s`.
- Bit counter `cnt` is ceil(log2(CLKS_PER_BIT)) bits wide. HALF = floor(CLKS_PER_BIT/2).
- Bit index `idx` is 3 bits. Shift register `sh` is 8 bits, filled LSB first.
- IDLE: when rx_s == 0, clear cnt and go to START.
- START: count to HALF-1, then re-sample rx_s.
  - rx_s == 0: clear cnt and idx, go to DATA.
  - rx_s == 1: false start, return to IDLE with no outputs.
- DATA: at cnt == CLKS_PER_BIT-1, sample rx_s into sh[idx] and clear cnt. After idx == 7, go to PARITY (macro) or STOP.
- PARITY (macro only): one bit period, then sample the parity bit.
  - Check: XOR of sh plus parity bit == PARITY_ODD, else error.
- STOP: one bit period, then sample rx_s.
  - Good frame (rx_s == 1, no parity error): Rx_Byte_out <= sh, pulse Rx_Valid_out, go to IDLE.
  - Parity error only: pulse Parity_Err_out, keep Rx_Byte_out, go to IDLE.
  - rx_s == 0: pulse Frame_Err_out, and also Parity_Err_out if the parity check failed. Keep Rx_Byte_out, go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. This blocks false starts during a held-low line.
- Rx_Valid_out, Frame_Err_out and Parity_Err_out are registered and never high for more than one cycle. Rx_Valid_out is never asserted together with either error pulse.
- Reset values: Rx_Byte_out = 8'h00, Rx_Valid_out = 0, Frame_Err_out = 0, Parity_Err_out = 0, Busy_out = 0. State = IDLE, cnt = 0, idx = 0, sh = 0, synchroniser = 11.
- Reset asserted mid-frame aborts immediately. After release the block waits in IDLE for the next falling edge; if the line is still low it treats it as a start bit and relies on the START recheck and stop-bit check.

## Timing
- The falling edge reaches rx_s 2 cycles after the pin.
- Bit k (k = 0..7) is sampled HALF + (k+1)·CLKS_PER_BIT cycles after the start edge is seen on rx_s.
- The stop bit is sampled at HALF + 9·CLKS_PER_BIT, or HALF + 10·CLKS_PER_BIT with the macro.
- Rx_Valid_out rises 1 cycle after the stop sample. Rx_Byte_out changes on that same edge.
- Back-to-back frames are supported with zero idle time. The return to IDLE happens at mid-stop-bit, ahead of the next start edge.
- Tolerated baud mismatch is ±4 % of CLKS_PER_BIT.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1 (PARITY_ODD = 0) or 8O1 (PARITY_ODD = 1).
  - PARITY state is present; Parity_Err_out is live.
- Not defined:
  - Frame is 8N1; no PARITY state.
  - Parity_Err_out is tied to 0.
  - PARITY_ODD is ignored.

## Test plan
- Run the bench with CLKS_PER_BIT = 16.
- Reset: hold RST low with the line idle → all outputs 0 and Rx_Byte_out = 8'h00. Release → Busy_out stays 0.
- Single frame 8'hA5 → Rx_Byte_out = 8'hA5 and a one-cycle Rx_Valid_out, 8 + 9·16 + 3 cycles after the pin's falling edge (±1 for the synchroniser edge).
- Back-to-back 8'h01, 8'hFF, 8'h00 with no idle gap → three valid pulses with the correct bytes, and no errors.
- Stop bit forced 0 on 8'h3C → Frame_Err_out pulses once, no Rx_Valid_out, Rx_Byte_out keeps its previous value. Line held low 40 cycles then released → no spurious start; the next frame 8'h55 is received.
- 5-cycle low glitch on the idle line → START recheck sees high, no output pulses, and Busy_out falls within 8 cycles.
- With `UART_RX_PARITY_EN`, PARITY_ODD = 0:
  - 8'h07 with parity bit 1 → valid.
  - 8'h07 with parity bit 0 → Parity_Err_out pulse, no valid.
- Reset mid-DATA of 8'hC3 → outputs return to reset values. The following frame 8'h12 is received correctly.
